// File: rtl/key_collect_pkg.sv
// Shared game constants: stage codes, object ROM, key/door slots, FSM states.
// Used by key_collect, obj_rom and the renderer.
package key_collect_pkg;

    localparam int COORD_W = 9;

    typedef enum logic [2:0] {
        ST_TITLE,
        ST_STAGE1,
        ST_SUCCESS1,
        ST_STAGE2,
        ST_SUCCESS2,
        ST_STAGE3,
        ST_SUCCESS3,
        ST_FAIL
    } game_stage_e;

    localparam logic [1:0] KEY0 = 2'd0;
    localparam logic [1:0] KEY1 = 2'd1;
    localparam logic [1:0] KEY2 = 2'd2;
    localparam logic [1:0] DOOR = 2'd3;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } obj_t;

    // Row 0 is the idle stage code and reads as all zeros.
    localparam obj_t OBJ_ROM [4][4] = '{
        '{'{9'd0,   9'd0},   '{9'd0,   9'd0},
          '{9'd0,   9'd0},   '{9'd0,   9'd0}},
        '{'{9'd80,  9'd50},  '{9'd200, 9'd90},
          '{9'd150, 9'd200}, '{9'd250, 9'd125}},
        '{'{9'd100, 9'd160}, '{9'd230, 9'd60},
          '{9'd70,  9'd220}, '{9'd250, 9'd125}},
        '{'{9'd180, 9'd210}, '{9'd90,  9'd80},
          '{9'd240, 9'd180}, '{9'd60,  9'd125}}
    };

    typedef enum logic [2:0] {
        KC_IDLE,
        KC_LOAD,
        KC_SEEK_KEY,
        KC_SEEK_DOOR,
        KC_DONE
    } kc_state_e;

    function automatic logic [1:0] key_slot(
        input logic [1:0] idx,
        input logic [1:0] rot
    );
        logic [2:0] sum;
        if (idx == DOOR) return DOOR;
        sum = {1'b0, idx} + {1'b0, rot};
        if (sum >= 3'd3) sum = sum - 3'd3;
        return sum[1:0];
    endfunction

endpackage

// File: rtl/key_collect_if.sv
// Game-play side bundle: player position and stage control in,
// target object, key count and pass pulse out.
interface key_collect_if;

    logic                                 stage_active;
    logic [1:0]                           stage_sel;
    logic                                 tick;
    logic [key_collect_pkg::COORD_W-1:0]  player_x;
    logic [key_collect_pkg::COORD_W-1:0]  player_y;
    logic [key_collect_pkg::COORD_W-1:0]  obj_x;
    logic [key_collect_pkg::COORD_W-1:0]  obj_y;
    logic                                 obj_valid;
    logic [1:0]                           key_find;
    logic                                 pass;

    modport master (
        output stage_active, stage_sel, tick, player_x, player_y,
        input  obj_x, obj_y, obj_valid, key_find, pass
    );

    modport slave (
        input  stage_active, stage_sel, tick, player_x, player_y,
        output obj_x, obj_y, obj_valid, key_find, pass
    );

endinterface

// File: rtl/key_collect_obj_rom.sv
// Combinational object coordinate lookup by (stage, slot).
module obj_rom
    import key_collect_pkg::*;
(
    input  logic [1:0]         i_stage,
    input  logic [1:0]         i_idx,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y
);

    obj_t w_ent;

    assign w_ent = OBJ_ROM[i_stage][i_idx];
    assign o_x   = w_ent.x;
    assign o_y   = w_ent.y;

endmodule

// File: rtl/key_collect.sv
// Key/door tracker for one stage; emits a single-cycle pass on door reach.
// Optional KEY_SHUFFLE_EN rotates the key order from an 8-bit LFSR.
module key_collect
    import key_collect_pkg::*;
#(
    parameter int HIT_R      = 5,
    parameter int HOLD_TICKS = 3
) (
    input  logic          clk,
    input  logic          rst,
    key_collect_if.slave  bus
);

    localparam logic [COORD_W:0] HIT_LIM   = (COORD_W+1)'(HIT_R);
    localparam logic [3:0]       HOLD_LAST = 4'(HOLD_TICKS - 1);

    kc_state_e          r_state;
    kc_state_e          w_state_nxt;
    logic [1:0]         r_stage_q;
    logic [1:0]         r_idx;
    logic [3:0]         r_hold;
    logic               r_hit;
    logic [COORD_W-1:0] r_obj_x;
    logic [COORD_W-1:0] r_obj_y;
    logic               r_valid;
    logic [1:0]         r_kf;
    logic               r_pass;

    logic               w_abort;
    logic               w_start;
    logic               w_tk;
    logic               w_accept;
    logic [1:0]         w_rom_idx;
    logic [COORD_W-1:0] w_rom_x;
    logic [COORD_W-1:0] w_rom_y;

    // One extra bit keeps the absolute difference free of wrap.
    logic [COORD_W:0]   w_px;
    logic [COORD_W:0]   w_py;
    logic [COORD_W:0]   w_ox;
    logic [COORD_W:0]   w_oy;
    logic [COORD_W:0]   w_dx;
    logic [COORD_W:0]   w_dy;
    logic               w_hit;

    assign w_px  = {1'b0, bus.player_x};
    assign w_py  = {1'b0, bus.player_y};
    assign w_ox  = {1'b0, r_obj_x};
    assign w_oy  = {1'b0, r_obj_y};
    assign w_dx  = (w_px >= w_ox) ? (w_px - w_ox) : (w_ox - w_px);
    assign w_dy  = (w_py >= w_oy) ? (w_py - w_oy) : (w_oy - w_py);
    assign w_hit = (w_dx < HIT_LIM) && (w_dy < HIT_LIM);

`ifdef KEY_SHUFFLE_EN
    logic [7:0] r_lfsr;
    logic [1:0] r_rot;
    logic       w_fb;
    logic [7:0] w_mod;

    assign w_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_mod = r_lfsr % 8'd3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 8'hA5;
            r_rot  <= 2'd0;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
            if (w_start) r_rot <= w_mod[1:0];
        end
    end

    assign w_rom_idx = key_slot(r_idx, r_rot);
`else
    assign w_rom_idx = r_idx;
`endif

    obj_rom u_rom (
        .i_stage (r_stage_q),
        .i_idx   (w_rom_idx),
        .o_x     (w_rom_x),
        .o_y     (w_rom_y)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= KC_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_abort     = (r_state != KC_IDLE) &&
                      (!bus.stage_active || bus.stage_sel != r_stage_q);
        w_start     = (r_state == KC_IDLE) && bus.stage_active &&
                      (bus.stage_sel != 2'd0);
        w_tk        = bus.tick && ((r_state == KC_SEEK_KEY) ||
                                   (r_state == KC_SEEK_DOOR));
        // Abort outranks a same-cycle accept.
        w_accept    = w_tk && r_hit && (r_hold == HOLD_LAST) && !w_abort;
        if (w_abort) begin
            w_state_nxt = KC_IDLE;
        end else begin
            unique case (r_state)
                KC_IDLE:      if (w_start) w_state_nxt = KC_LOAD;
                KC_LOAD:      w_state_nxt = (r_idx == DOOR) ? KC_SEEK_DOOR
                                                            : KC_SEEK_KEY;
                KC_SEEK_KEY:  if (w_accept) w_state_nxt = KC_LOAD;
                KC_SEEK_DOOR: if (w_accept) w_state_nxt = KC_DONE;
                KC_DONE:      w_state_nxt = KC_DONE;
                default:      w_state_nxt = KC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage_q <= 2'd0;
            r_idx     <= 2'd0;
            r_hold    <= 4'd0;
            r_hit     <= 1'b0;
            r_obj_x   <= '0;
            r_obj_y   <= '0;
            r_valid   <= 1'b0;
            r_kf      <= 2'd0;
            r_pass    <= 1'b0;
        end else begin
            r_hit  <= w_hit;
            r_pass <= 1'b0;
            if (w_abort) begin
                r_kf    <= 2'd0;
                r_idx   <= 2'd0;
                r_hold  <= 4'd0;
                r_valid <= 1'b0;
            end else begin
                unique case (r_state)
                    KC_IDLE: begin
                        r_stage_q <= bus.stage_sel;
                        r_idx     <= 2'd0;
                        r_kf      <= 2'd0;
                        r_hold    <= 4'd0;
                        r_valid   <= 1'b0;
                    end
                    KC_LOAD: begin
                        r_obj_x <= w_rom_x;
                        r_obj_y <= w_rom_y;
                        r_valid <= 1'b1;
                        r_hold  <= 4'd0;
                    end
                    KC_SEEK_KEY, KC_SEEK_DOOR: begin
                        if (w_accept) begin
                            r_hold  <= 4'd0;
                            r_valid <= 1'b0;
                            if (r_state == KC_SEEK_DOOR) begin
                                r_pass <= 1'b1;
                            end else begin
                                if (r_kf != 2'd3)  r_kf  <= r_kf + 2'd1;
                                if (r_idx != DOOR) r_idx <= r_idx + 2'd1;
                            end
                        end else if (w_tk) begin
                            if (!r_hit)              r_hold <= 4'd0;
                            else if (r_hold != 4'hF) r_hold <= r_hold + 4'd1;
                        end
                    end
                    KC_DONE: r_valid <= 1'b0;
                    default: r_valid <= 1'b0;
                endcase
            end
        end
    end

    assign bus.obj_x     = r_obj_x;
    assign bus.obj_y     = r_obj_y;
    assign bus.obj_valid = r_valid;
    assign bus.key_find  = r_kf;
    assign bus.pass      = r_pass;

endmodule

// File: tb/tb_key_collect.sv
// Directed bench for key_collect: hit-window vector table plus
// hand-written stage, door and abort sequences.
module tb_key_collect;
    import key_collect_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   pass_cnt = 0;

    key_collect_if ifc ();

    key_collect #(.HIT_R(5), .HOLD_TICKS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ifc.pass === 1'b1) pass_cnt++;

    typedef struct {
        logic [8:0] px;
        logic [8:0] py;
        logic [1:0] kf;
        logic [8:0] ox;
    } vec_t;

    vec_t vecs [10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifc.stage_active = 1'b0;
        ifc.stage_sel = 2'd0;
        ifc.tick = 1'b0;
        ifc.player_x = '0;
        ifc.player_y = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic start(input logic [1:0] s);
        ifc.stage_active = 1'b1;
        ifc.stage_sel = s;
        step();
        step();
    endtask

    task automatic do_tick(input logic [8:0] x, input logic [8:0] y);
        ifc.player_x = x;
        ifc.player_y = y;
        step();
        ifc.tick = 1'b1;
        step();
        ifc.tick = 1'b0;
    endtask

    task automatic hold(input logic [8:0] x, input logic [8:0] y, input int n);
        for (int k = 0; k < n; k++) do_tick(x, y);
    endtask

    initial begin
        vecs[0] = '{9'd82,  9'd52,  2'd1, 9'd200};
        vecs[1] = '{9'd85,  9'd50,  2'd0, 9'd80};
        vecs[2] = '{9'd84,  9'd54,  2'd1, 9'd200};
        vecs[3] = '{9'd0,   9'd50,  2'd0, 9'd80};
        vecs[4] = '{9'd76,  9'd46,  2'd1, 9'd200};
        vecs[5] = '{9'd75,  9'd50,  2'd0, 9'd80};
        vecs[6] = '{9'd80,  9'd45,  2'd0, 9'd80};
        vecs[7] = '{9'd80,  9'd55,  2'd0, 9'd80};
        vecs[8] = '{9'd511, 9'd511, 2'd0, 9'd80};
        vecs[9] = '{9'd80,  9'd50,  2'd1, 9'd200};

        do_reset();
        chk("rst_obj_x", int'(ifc.obj_x), 0);
        chk("rst_obj_y", int'(ifc.obj_y), 0);
        chk("rst_valid", int'(ifc.obj_valid), 0);
        chk("rst_kf", int'(ifc.key_find), 0);
        chk("rst_pass", int'(ifc.pass), 0);

        start(2'd1);
        chk("s1_obj_x", int'(ifc.obj_x), 80);
        chk("s1_obj_y", int'(ifc.obj_y), 50);
        chk("s1_valid", int'(ifc.obj_valid), 1);
        chk("s1_kf", int'(ifc.key_find), 0);

        for (int i = 0; i < 10; i++) begin
            do_reset();
            start(2'd1);
            hold(vecs[i].px, vecs[i].py, 3);
            step();
            chk($sformatf("vec%0d_kf", i), int'(ifc.key_find), int'(vecs[i].kf));
            chk($sformatf("vec%0d_ox", i), int'(ifc.obj_x), int'(vecs[i].ox));
        end

        // Two hits, a miss, then one hit: counter restarted.
        do_reset();
        start(2'd1);
        hold(9'd82, 9'd52, 2);
        do_tick(9'd10, 9'd10);
        hold(9'd82, 9'd52, 1);
        chk("miss_kf0", int'(ifc.key_find), 0);
        hold(9'd82, 9'd52, 2);
        step();
        chk("miss_kf1", int'(ifc.key_find), 1);
        chk("miss_oy", int'(ifc.obj_y), 90);

        // Stage 2 full run to door.
        do_reset();
        start(2'd2);
        chk("s2_k0x", int'(ifc.obj_x), 100);
        hold(9'd100, 9'd160, 3);
        step();
        chk("s2_k1x", int'(ifc.obj_x), 230);
        hold(9'd230, 9'd60, 3);
        step();
        chk("s2_k2x", int'(ifc.obj_x), 70);
        hold(9'd70, 9'd220, 3);
        step();
        chk("s2_door_x", int'(ifc.obj_x), 250);
        chk("s2_door_y", int'(ifc.obj_y), 125);
        chk("s2_kf3", int'(ifc.key_find), 3);
        chk("s2_pass_pre", int'(ifc.pass), 0);
        hold(9'd250, 9'd125, 3);
        chk("s2_pass_hi", int'(ifc.pass), 1);
        chk("s2_valid_lo", int'(ifc.obj_valid), 0);
        step();
        chk("s2_pass_lo", int'(ifc.pass), 0);
        hold(9'd250, 9'd125, 3);
        chk("s2_done_kf", int'(ifc.key_find), 3);
        chk("s2_pass_cnt", pass_cnt, 1);
        ifc.stage_active = 1'b0;
        step();
        chk("s2_exit_kf", int'(ifc.key_find), 0);

        // Stage 3 abort with two keys.
        do_reset();
        start(2'd3);
        hold(9'd180, 9'd210, 3);
        step();
        hold(9'd90, 9'd80, 3);
        step();
        chk("s3_kf2", int'(ifc.key_find), 2);
        ifc.stage_active = 1'b0;
        step();
        chk("s3_abort_kf", int'(ifc.key_find), 0);
        chk("s3_abort_valid", int'(ifc.obj_valid), 0);
        start(2'd3);
        chk("s3_re_x", int'(ifc.obj_x), 180);
        chk("s3_re_y", int'(ifc.obj_y), 210);

        // Abort on the same cycle as the door accept.
        hold(9'd180, 9'd210, 3);
        step();
        hold(9'd90, 9'd80, 3);
        step();
        hold(9'd240, 9'd180, 3);
        step();
        chk("s3_door_x", int'(ifc.obj_x), 60);
        hold(9'd60, 9'd125, 2);
        ifc.player_x = 9'd60;
        ifc.player_y = 9'd125;
        step();
        ifc.tick = 1'b1;
        ifc.stage_active = 1'b0;
        step();
        ifc.tick = 1'b0;
        chk("race_pass", int'(ifc.pass), 0);
        chk("race_kf", int'(ifc.key_find), 0);
        chk("race_valid", int'(ifc.obj_valid), 0);
        step();
        chk("race_pass_cnt", pass_cnt, 1);

        // Stage select change aborts and restarts.
        do_reset();
        start(2'd1);
        hold(9'd80, 9'd50, 3);
        step();
        chk("sel_kf1", int'(ifc.key_find), 1);
        ifc.stage_sel = 2'd2;
        step();
        chk("sel_abort_kf", int'(ifc.key_find), 0);
        chk("sel_abort_valid", int'(ifc.obj_valid), 0);
        step();
        step();
        chk("sel_s2_x", int'(ifc.obj_x), 100);
        chk("sel_s2_y", int'(ifc.obj_y), 160);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
